// File: rtl/io_port_pkg.sv
// Shared constants for the memory-mapped IO port block: register addresses
// and the core data-bus width.
package io_port_pkg;

  localparam int unsigned BUS_W = 32;

  localparam logic [BUS_W-1:0] ADDR_SW   = 32'd1;
  localparam logic [BUS_W-1:0] ADDR_BTN  = 32'd2;
  localparam logic [BUS_W-1:0] ADDR_EDGE = 32'd3;
  localparam logic [BUS_W-1:0] ADDR_LED  = 32'd4;
  localparam logic [BUS_W-1:0] ADDR_MASK = 32'd5;

endpackage

// File: rtl/io_debounce.sv
// Single-bit debouncer: the stable value follows the synchronised input only
// after it has differed for DEBOUNCE_CYCLES consecutive samples.
module io_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Counter saturates at CNT_LAST by toggling and clearing, so it never wraps.
  assign accept = (din != dout) && (cnt == CNT_LAST);
  assign rise   = accept & din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (accept) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped switch/button/LED port with edge capture and masked irq.
// Define IO_PORT_DEBOUNCE_EN to insert a debouncer on every button bit.
module io_port_ctrl
  import io_port_pkg::*;
#(
  parameter int unsigned IN_WIDTH        = 16,
  parameter int unsigned BTN_WIDTH       = 5,
  parameter int unsigned OUT_WIDTH       = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          io_address,
  input  logic [31:0]          io_write_value,
  input  logic                 io_write_en,
  input  logic                 io_read_en,
  output logic [31:0]          io_read_value,
  input  logic [IN_WIDTH-1:0]  sw,
  input  logic [BTN_WIDTH-1:0] btn,
  output logic [OUT_WIDTH-1:0] led,
  output logic                 irq
);

  logic [IN_WIDTH-1:0]  sw_p0, sw_p1;
  logic [BTN_WIDTH-1:0] btn_p0, btn_p1;
  logic [BTN_WIDTH-1:0] btn_db, btn_rise;
  logic [BTN_WIDTH-1:0] edge_q, mask_q, edge_clr;
  logic [BUS_W-1:0]     rd_data;
  logic                 wr_edge, wr_led, wr_mask;
  logic                 unused_wdata;

  assign unused_wdata = ^io_write_value;

  // Stage p0 -> p1: two-flop synchroniser for the asynchronous pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_p0  <= '0;
      sw_p1  <= '0;
      btn_p0 <= '0;
      btn_p1 <= '0;
    end else begin
      sw_p0  <= sw;
      sw_p1  <= sw_p0;
      btn_p0 <= btn;
      btn_p1 <= btn_p0;
    end
  end

`ifdef IO_PORT_DEBOUNCE_EN
  for (genvar i = 0; i < int'(BTN_WIDTH); i++) begin : g_db
    io_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (btn_p1[i]),
      .dout (btn_db[i]),
      .rise (btn_rise[i])
    );
  end
`else
  logic [BTN_WIDTH-1:0] btn_prev;
  logic                 unused_debounce_cfg;

  assign unused_debounce_cfg = (DEBOUNCE_CYCLES == 0);
  assign btn_db   = btn_p1;
  assign btn_rise = btn_db & ~btn_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_prev <= '0;
    else        btn_prev <= btn_db;
  end
`endif

  assign wr_edge  = io_write_en && (io_address == ADDR_EDGE);
  assign wr_led   = io_write_en && (io_address == ADDR_LED);
  assign wr_mask  = io_write_en && (io_address == ADDR_MASK);
  assign edge_clr = wr_edge ? io_write_value[BTN_WIDTH-1:0] : '0;

  // New rises are OR-ed in after the clear so a coincident set survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= '0;
      mask_q <= '0;
      led    <= '0;
      irq    <= 1'b0;
    end else begin
      edge_q <= (edge_q & ~edge_clr) | btn_rise;
      if (wr_mask) mask_q <= io_write_value[BTN_WIDTH-1:0];
      if (wr_led)  led    <= io_write_value[OUT_WIDTH-1:0];
      irq    <= |(edge_q & mask_q);
    end
  end

  always_comb begin
    rd_data = '0;
    case (io_address)
      ADDR_SW:   rd_data[IN_WIDTH-1:0]  = sw_p1;
      ADDR_BTN:  rd_data[BTN_WIDTH-1:0] = btn_db;
      ADDR_EDGE: rd_data[BTN_WIDTH-1:0] = edge_q;
      ADDR_LED:  rd_data[OUT_WIDTH-1:0] = led;
      ADDR_MASK: rd_data[BTN_WIDTH-1:0] = mask_q;
      default:   rd_data = '0;
    endcase
  end

  // Read data sees register state before any same-edge write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          io_read_value <= '0;
    else if (io_read_en) io_read_value <= rd_data;
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl with DEBOUNCE_CYCLES=4; button timing
// expectations follow whether IO_PORT_DEBOUNCE_EN is defined.
module tb_io_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] io_address;
  logic [31:0] io_write_value;
  logic        io_write_en;
  logic        io_read_en;
  logic [31:0] io_read_value;
  logic [15:0] sw;
  logic [4:0]  btn;
  logic [15:0] led;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  io_port_ctrl #(
    .IN_WIDTH(16), .BTN_WIDTH(5), .OUT_WIDTH(16), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .io_address    (io_address),
    .io_write_value(io_write_value),
    .io_write_en   (io_write_en),
    .io_read_en    (io_read_en),
    .io_read_value (io_read_value),
    .sw            (sw),
    .btn           (btn),
    .led           (led),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_address     = a;
    io_write_value = d;
    io_write_en    = 1'b1;
    step(1);
    io_write_en    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    io_address = a;
    io_read_en = 1'b1;
    step(1);
    io_read_en = 1'b0;
    v = io_read_value;
  endtask

  logic [31:0] v;

  initial begin
    rst_n = 1'b1; io_address = '0; io_write_value = '0;
    io_write_en = 1'b0; io_read_en = 1'b0; sw = '0; btn = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_led", 32'(led), 32'h0);
    check("rst_rdval", io_read_value, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // LED write/read and read-hold
    wr(32'd4, 32'h0000_A5A5);
    check("led_after_wr", 32'(led), 32'h0000_A5A5);
    rd(32'd4, v);
    check("rd_led", v, 32'h0000_A5A5);
    io_address = 32'd9;
    step(2);
    check("rd_hold", io_read_value, 32'h0000_A5A5);

    wr(32'd5, 32'h0000_0001);
    rd(32'd5, v);
    check("rd_mask", v, 32'h0000_0001);

    // Switches, unmapped reads, RO write ignored
    sw = 16'h1234;
    step(3);
    rd(32'd1, v);
    check("rd_sw", v, 32'h0000_1234);
    rd(32'd9, v);
    check("rd_unmapped", v, 32'h0);
    rd(32'd2, v);
    check("rd_btn_idle", v, 32'h0);
    wr(32'd1, 32'hFFFF_FFFF);
    rd(32'd1, v);
    check("rd_sw_ro", v, 32'h0000_1234);

    // Same-cycle read and write to LED returns the old value
    io_address = 32'd4; io_write_value = 32'h0000_5A5A;
    io_write_en = 1'b1; io_read_en = 1'b1;
    step(1);
    io_write_en = 1'b0; io_read_en = 1'b0;
    check("rw_same_rd", io_read_value, 32'h0000_A5A5);
    check("rw_same_led", 32'(led), 32'h0000_5A5A);

`ifdef IO_PORT_DEBOUNCE_EN
    // Bouncing button, then held: one edge, six edges after final rise
    for (int i = 0; i < 10; i++) begin
      btn[0] = (i % 2 == 0);
      step(1);
    end
    btn[0] = 1'b1;
    step(5);
    rd(32'd3, v);
    check("edge_early", v, 32'h0);
    check("irq_lag", 32'(irq), 32'h0);
    rd(32'd3, v);
    check("edge_set", v, 32'h0000_0001);
    check("irq_set", 32'(irq), 32'h1);
    rd(32'd2, v);
    check("rd_btn_db", v, 32'h0000_0001);

    wr(32'd3, 32'h0000_0001);
    check("irq_w1c_lag", 32'(irq), 32'h1);
    step(1);
    check("irq_w1c", 32'(irq), 32'h0);
    step(6);
    rd(32'd3, v);
    check("edge_once", v, 32'h0);

    // W1C landing on the same edge as a new rise
    btn[0] = 1'b0;
    step(8);
    btn[0] = 1'b1;
    step(5);
    wr(32'd3, 32'h0000_0001);
    rd(32'd3, v);
    check("edge_set_wins", v, 32'h0000_0001);

    // Reset mid-debounce with the button held
    btn[0] = 1'b0;
    step(8);
    btn[0] = 1'b1;
    step(3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_led", 32'(led), 32'h0);
    check("mid_rst_rdval", io_read_value, 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(5);
    rd(32'd3, v);
    check("post_rst_early", v, 32'h0);
    rd(32'd3, v);
    check("post_rst_edge", v, 32'h0000_0001);
    rd(32'd5, v);
    check("post_rst_mask", v, 32'h0);
    check("post_rst_irq", 32'(irq), 32'h0);
`else
    // Without debouncing an edge lands three edges after the pin rises
    btn = 5'b00010;
    step(2);
    rd(32'd3, v);
    check("edge_early", v, 32'h0);
    rd(32'd3, v);
    check("edge_set", v, 32'h0000_0002);
    rd(32'd2, v);
    check("rd_btn", v, 32'h0000_0002);
    check("irq_masked", 32'(irq), 32'h0);
    wr(32'd5, 32'h0000_0003);
    check("irq_lag", 32'(irq), 32'h0);
    step(1);
    check("irq_set", 32'(irq), 32'h1);

    btn = 5'b00011;
    step(2);
    wr(32'd3, 32'h0000_0001);
    rd(32'd3, v);
    check("edge_set_wins", v, 32'h0000_0003);
    wr(32'd3, 32'h0000_0003);
    rd(32'd3, v);
    check("edge_w1c", v, 32'h0);

    rd(32'd5, v);
    check("rd_mask3", v, 32'h0000_0003);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_led", 32'(led), 32'h0);
    check("mid_rst_rdval", io_read_value, 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(2);
    rd(32'd3, v);
    check("post_rst_early", v, 32'h0);
    rd(32'd3, v);
    check("post_rst_edge", v, 32'h0000_0003);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
